axi_ts_seq: RTL
===============

// Module: axi_ts_seq
// PURPOSE
// - Parametrised trigger sequencer; next generation of the axi_ts trigger-subsystem core.
// - Runs init -> arm -> trigger -> measure sweeps with per-source edge-detected external triggers.
// - Shadows the sweep configuration at init; exposes live arm/trigger counters for readback.
// - Sits between the axi_ts register bank (ctrl_*/stat_*) and the measurement engine (measure_*).
// PARAMETERS
// - N_EXT        8   number of external trigger inputs
// - CNT_W        32  width of arm/trigger count config and counters
// - SYNC_STAGES  2   synchroniser flops per ext_trigger bit (>=2)
// PORTS
// - clk                     in   1      system clock
// - rst                     in   1      reset; asynchronous, active-high
// - rtc_sec, rtc_nsec       in   32,32  RTC time, clk domain
// - ext_trigger             in   N_EXT  asynchronous external trigger lines
// - measure_start           out  1      measurement request, held until measure_ready
// - measure_ready           in   1      engine accepted request
// - measure_done            in   1      engine finished, 1-cycle pulse
// - ctrl_abort              in   1      pulse: return to IDLE
// - ctrl_init_immediate     in   1      pulse: start one sweep
// - ctrl_init_continuous    in   1      level: re-init automatically after each sweep
// - ctrl_arm_immediate      in   1      pulse: software arm event
// - ctrl_arm_source         in   N_EXT  ext_trigger mask for arm events
// - ctrl_arm_edge           in   1      0 = rising edge, 1 = falling edge
// - ctrl_arm_count          in   CNT_W  arms per sweep (0 treated as 1)
// - ctrl_trigger_immediate  in   1      pulse: software trigger event
// - ctrl_trigger_source     in   N_EXT  ext_trigger mask for trigger events
// - ctrl_trigger_edge       in   1      0 = rising edge, 1 = falling edge
// - ctrl_trigger_count      in   CNT_W  triggers per arm (0 treated as 1)
// - stat_operation_complete, stat_sweeping, stat_waiting_for_arm, stat_waiting_for_trigger,
//   stat_measuring          out  1 each state flags
// - stat_arm_count, stat_trigger_count  out  CNT_W  live counters
// - stat_trig_sec, stat_trig_nsec       out  32,32  timestamp of last accepted trigger
// - stat_trig_src           out  N_EXT  ext sources active at that trigger
// - stat_trig_valid         out  1      1-cycle pulse on timestamp update
// BEHAVIOUR
// - Async rst forces all outputs and registers to 0 and the state to IDLE, including mid-operation.
// - ext_trigger passes through SYNC_STAGES flops, then an edge-detect flop.
// - Edge event = edge of selected polarity on any bit enabled in *_source, ORed with *_immediate.
// - Pin edge reaches event at SYNC_STAGES+1 clk.
// - Events arriving outside the matching wait state are dropped; there is no queue.
// - States: IDLE, ARM_WAIT, TRIG_WAIT, MEAS_START, MEAS_WAIT. ctrl_abort has top priority: any state -> IDLE.
// - IDLE -> ARM_WAIT on init_immediate|init_continuous.
//   - Shadows arm/trigger count and source/edge config.
//   - Clears both counters.
// - ARM_WAIT -> TRIG_WAIT on arm event; arm_cnt++. TRIG_WAIT -> MEAS_START on trigger event.
// - MEAS_START: measure_start=1; on measure_ready -> MEAS_WAIT.
//   - measure_start deasserts the cycle after ready is sampled.
//   - ready and done in the same cycle count as a completed measurement.
// - On measure_done (MEAS_WAIT only), trig_cnt++, then:
//   - trig_cnt < trig_count -> TRIG_WAIT.
//   - elif arm_cnt < arm_count -> ARM_WAIT; trig_cnt cleared.
//   - elif init_continuous -> ARM_WAIT; both counters cleared; config re-shadowed.
//   - else -> IDLE.
// - Abort from MEAS_*: measure_start drops next cycle; a late measure_done is ignored.
//   - Counters hold their value for readback until the next init.
// - Counters never exceed CNT_W-bit config, so no wrap; config changes mid-sweep take effect at next init.
// - stat_* flags are registered from state_next, so they track the state with 0 extra latency.
//   - operation_complete = IDLE.
//   - sweeping = not IDLE.
//   - waiting_for_arm = ARM_WAIT.
//   - waiting_for_trigger = TRIG_WAIT.
//   - measuring = MEAS_*.
// CONFIGURATION
// - AXI_TS_TIMESTAMP_EN defined:
//   - On the trigger-accept cycle, rtc_sec/nsec and the source edges are captured into stat_trig_*.
//   - stat_trig_valid pulses on the following cycle.
// - AXI_TS_TIMESTAMP_EN undefined: stat_trig_sec/nsec/src/valid tied to 0; no capture registers built.
// TESTING
// - arm_count=2, trig_count=3, immediate pulses, ready/done 1 clk later:
//   exactly 6 measure_start pulses, then IDLE, stat_arm_count=2.
// - trigger_source=0x08, edge=0, SYNC_STAGES=2, rise on ext_trigger[3]:
//   TRIG_WAIT exits 3 clk after edge; a rise on ext_trigger[2] is ignored.
// - trigger_edge=1, bit 0 enabled: falling edge fires; rising edge does not.
// - abort in MEAS_WAIT: IDLE next cycle, measure_start=0, late measure_done ignored, counters held.
// - init_continuous=1, counts 0/0 (treated 1/1): sweeps loop.
//   Clearing continuous mid-sweep gives IDLE after the current measure_done.
// - TIMESTAMP_EN, rtc_sec=0x10, rtc_nsec=500 at accept: stat_trig_sec=0x10, stat_trig_nsec=500, valid pulse +1 clk.

Source files
------------

// File: rtl/axi_ts_seq.sv
// Trigger sequencer: init -> arm -> trigger -> measure sweeps with synchronised, edge-detected external triggers.
// Define AXI_TS_TIMESTAMP_EN to build the trigger timestamp capture registers (stat_trig_*).
module axi_ts_seq #(
  parameter int N_EXT       = 8,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rtc_sec,
  input  logic [31:0]      rtc_nsec,
  input  logic [N_EXT-1:0] ext_trigger,
  output logic             measure_start,
  input  logic             measure_ready,
  input  logic             measure_done,
  input  logic             ctrl_abort,
  input  logic             ctrl_init_immediate,
  input  logic             ctrl_init_continuous,
  input  logic             ctrl_arm_immediate,
  input  logic [N_EXT-1:0] ctrl_arm_source,
  input  logic             ctrl_arm_edge,
  input  logic [CNT_W-1:0] ctrl_arm_count,
  input  logic             ctrl_trigger_immediate,
  input  logic [N_EXT-1:0] ctrl_trigger_source,
  input  logic             ctrl_trigger_edge,
  input  logic [CNT_W-1:0] ctrl_trigger_count,
  output logic             stat_operation_complete,
  output logic             stat_sweeping,
  output logic             stat_waiting_for_arm,
  output logic             stat_waiting_for_trigger,
  output logic             stat_measuring,
  output logic [CNT_W-1:0] stat_arm_count,
  output logic [CNT_W-1:0] stat_trigger_count,
  output logic [31:0]      stat_trig_sec,
  output logic [31:0]      stat_trig_nsec,
  output logic [N_EXT-1:0] stat_trig_src,
  output logic             stat_trig_valid
);

  typedef enum logic [2:0] {IDLE, ARM_WAIT, TRIG_WAIT, MEAS_START, MEAS_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   arm_cnt_q, arm_cnt_d, trig_cnt_q, trig_cnt_d, trig_inc;
  logic [CNT_W-1:0]   arm_count_q, trig_count_q;
  logic [N_EXT-1:0]   arm_src_q, trig_src_q;
  logic               arm_edge_q, trig_edge_q;
  logic [N_EXT-1:0]   sync_q [SYNC_STAGES];
  logic [N_EXT-1:0]   prev_q, ext_now, rise, fall, trig_hits;
  logic               arm_ev, trig_ev, shadow_en, accept, done_now;
  logic               measure_start_q, op_complete_q, sweeping_q, wait_arm_q, wait_trig_q, measuring_q;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= ext_trigger;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges are combinational off the last sync flop so a pin edge moves the FSM SYNC_STAGES+1 clocks later.
  assign ext_now   = sync_q[SYNC_STAGES-1];
  assign rise      = ext_now & ~prev_q;
  assign fall      = ~ext_now & prev_q;
  assign arm_ev    = ctrl_arm_immediate | (|((arm_edge_q ? fall : rise) & arm_src_q));
  assign trig_hits = (trig_edge_q ? fall : rise) & trig_src_q;
  assign trig_ev   = ctrl_trigger_immediate | (|trig_hits);
  assign trig_inc  = trig_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    trig_cnt_d = trig_cnt_q;
    shadow_en  = 1'b0;
    accept     = 1'b0;
    done_now   = 1'b0;
    case (state_q)
      IDLE: if (ctrl_init_immediate || ctrl_init_continuous) begin
        state_d    = ARM_WAIT;
        shadow_en  = 1'b1;
        arm_cnt_d  = '0;
        trig_cnt_d = '0;
      end
      ARM_WAIT: if (arm_ev) begin
        state_d   = TRIG_WAIT;
        arm_cnt_d = arm_cnt_q + CNT_W'(1);
      end
      TRIG_WAIT: if (trig_ev) begin
        state_d = MEAS_START;
        accept  = 1'b1;
      end
      MEAS_START: if (measure_ready) begin
        state_d  = MEAS_WAIT;
        done_now = measure_done;
      end
      MEAS_WAIT: done_now = measure_done;
      default: state_d = IDLE;
    endcase
    if (done_now) begin
      if (trig_inc < trig_count_q) begin
        state_d    = TRIG_WAIT;
        trig_cnt_d = trig_inc;
      end else if (arm_cnt_q < arm_count_q) begin
        state_d    = ARM_WAIT;
        trig_cnt_d = '0;
      end else if (ctrl_init_continuous) begin
        state_d    = ARM_WAIT;
        arm_cnt_d  = '0;
        trig_cnt_d = '0;
        shadow_en  = 1'b1;
      end else begin
        state_d    = IDLE;
        trig_cnt_d = trig_inc;
      end
    end
    // Abort overrides everything; counters keep their value for readback.
    if (ctrl_abort) begin
      state_d    = IDLE;
      arm_cnt_d  = arm_cnt_q;
      trig_cnt_d = trig_cnt_q;
      shadow_en  = 1'b0;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      arm_cnt_q       <= '0;
      trig_cnt_q      <= '0;
      arm_count_q     <= '0;
      trig_count_q    <= '0;
      arm_src_q       <= '0;
      trig_src_q      <= '0;
      arm_edge_q      <= 1'b0;
      trig_edge_q     <= 1'b0;
      measure_start_q <= 1'b0;
      op_complete_q   <= 1'b0;
      sweeping_q      <= 1'b0;
      wait_arm_q      <= 1'b0;
      wait_trig_q     <= 1'b0;
      measuring_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      if (shadow_en) begin
        arm_count_q  <= at_least_one(ctrl_arm_count);
        trig_count_q <= at_least_one(ctrl_trigger_count);
        arm_src_q    <= ctrl_arm_source;
        trig_src_q   <= ctrl_trigger_source;
        arm_edge_q   <= ctrl_arm_edge;
        trig_edge_q  <= ctrl_trigger_edge;
      end
      measure_start_q <= (state_d == MEAS_START);
      op_complete_q   <= (state_d == IDLE);
      sweeping_q      <= (state_d != IDLE);
      wait_arm_q      <= (state_d == ARM_WAIT);
      wait_trig_q     <= (state_d == TRIG_WAIT);
      measuring_q     <= (state_d == MEAS_START) || (state_d == MEAS_WAIT);
    end
  end

  assign measure_start            = measure_start_q;
  assign stat_operation_complete  = op_complete_q;
  assign stat_sweeping            = sweeping_q;
  assign stat_waiting_for_arm     = wait_arm_q;
  assign stat_waiting_for_trigger = wait_trig_q;
  assign stat_measuring           = measuring_q;
  assign stat_arm_count           = arm_cnt_q;
  assign stat_trigger_count       = trig_cnt_q;

`ifdef AXI_TS_TIMESTAMP_EN
  logic [31:0]      ts_sec_q, ts_nsec_q;
  logic [N_EXT-1:0] ts_src_q;
  logic             ts_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_sec_q   <= '0;
      ts_nsec_q  <= '0;
      ts_src_q   <= '0;
      ts_valid_q <= 1'b0;
    end else begin
      ts_valid_q <= accept;
      if (accept) begin
        ts_sec_q  <= rtc_sec;
        ts_nsec_q <= rtc_nsec;
        ts_src_q  <= trig_hits;
      end
    end
  end

  assign stat_trig_sec   = ts_sec_q;
  assign stat_trig_nsec  = ts_nsec_q;
  assign stat_trig_src   = ts_src_q;
  assign stat_trig_valid = ts_valid_q;
`else
  logic unused_ts;
  assign unused_ts       = ^{rtc_sec, rtc_nsec, accept};
  assign stat_trig_sec   = '0;
  assign stat_trig_nsec  = '0;
  assign stat_trig_src   = '0;
  assign stat_trig_valid = 1'b0;
`endif

endmodule
